// File: rtl/relay_hold_ctrl.sv
// Relay sequencer: merges a debounced toggle switch and host on/off pulses,
// enforcing minimum energised/de-energised dwell times and an optional auto-off.
module relay_hold_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 32'd500000,
  parameter int unsigned MIN_ON_CYC   = 32'd5000000,
  parameter int unsigned MIN_OFF_CYC  = 32'd5000000,
  parameter int unsigned AUTO_OFF_CYC = 32'd0,
  parameter int unsigned CNT_W        = 32'd32
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Switch_i,
  input  logic       Cmd_on_i,
  input  logic       Cmd_off_i,
  output logic       Relay_o,
  output logic       Busy_o,
  output logic [1:0] State_o,
  output logic       Timeout_o
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_ON_HOLD  = 2'b01,
    ST_ON       = 2'b10,
    ST_OFF_HOLD = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYC - 32'd1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYC - 32'd1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_OFF_CYC - 32'd1);
  localparam logic             AUTO_EN   = (AUTO_OFF_CYC != 32'd0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             sw_press_q, sw_press_d;
  logic             desired_q, desired_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  logic             relay_q, relay_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             timeout_fire_s;

  // Next-state logic for debounce, request latch and relay FSM
  always_comb begin
    deb_d      = deb_q;
    deb_cnt_d  = CNT_ZERO;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = sat_inc(deb_cnt_q);
      end
    end else begin
      deb_cnt_d = CNT_ZERO;
    end
    sw_press_d = deb_d & ~deb_q;

    timeout_fire_s = AUTO_EN && (state_q == ST_ON) && desired_q && (auto_cnt_q == AUTO_LAST);

    // Auto-off beats every request; host commands beat the switch.
    if (timeout_fire_s) begin
      desired_d = 1'b0;
    end else if (Cmd_off_i) begin
      desired_d = 1'b0;
    end else if (Cmd_on_i) begin
      desired_d = 1'b1;
    end else if (sw_press_q) begin
      desired_d = ~desired_q;
    end else begin
      desired_d = desired_q;
    end

    state_d    = state_q;
    hold_cnt_d = CNT_ZERO;
    auto_cnt_d = CNT_ZERO;
    case (state_q)
      ST_OFF: begin
        if (desired_q) begin
          state_d = ST_ON_HOLD;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_ON_HOLD: begin
        if (hold_cnt_q == ON_LAST) begin
          state_d = desired_q ? ST_ON : ST_OFF_HOLD;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      ST_ON: begin
        if (!desired_q || timeout_fire_s) begin
          state_d = ST_OFF_HOLD;
        end else begin
          auto_cnt_d = sat_inc(auto_cnt_q);
        end
      end
      ST_OFF_HOLD: begin
        if (hold_cnt_q == OFF_LAST) begin
          state_d = desired_q ? ST_ON_HOLD : ST_OFF;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      default: begin
        state_d = ST_OFF_HOLD;
      end
    endcase

    relay_d   = (state_d == ST_ON_HOLD) || (state_d == ST_ON);
    busy_d    = (state_d == ST_ON_HOLD) || (state_d == ST_OFF_HOLD);
    timeout_d = timeout_fire_s;
  end

  // State and output registers; reset lands in OFF_HOLD so the relay rests first
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= CNT_ZERO;
      sw_press_q <= 1'b0;
      desired_q  <= 1'b0;
      state_q    <= ST_OFF_HOLD;
      hold_cnt_q <= CNT_ZERO;
      auto_cnt_q <= CNT_ZERO;
      relay_q    <= 1'b0;
      busy_q     <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      sync1_q    <= Switch_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      sw_press_q <= sw_press_d;
      desired_q  <= desired_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      relay_q    <= relay_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Relay_o   = relay_q;
  assign Busy_o    = busy_q;
  assign State_o   = state_q;
  assign Timeout_o = timeout_q;

endmodule

// File: tb/tb_relay_hold_ctrl.sv
// Scoreboard bench for relay_hold_ctrl: each stimulus cycle queues the expected
// {Relay, Busy, State, Timeout} after the next edge; a monitor pops and compares.
module tb_relay_hold_ctrl;

  logic       clk = 1'b0;
  logic       Reset_i = 1'b1;
  logic       Switch_i = 1'b0;
  logic       Cmd_on_i = 1'b0;
  logic       Cmd_off_i = 1'b0;
  logic       Relay_o, Busy_o, Timeout_o;
  logic [1:0] State_o;

  typedef struct {
    string      tag;
    logic [4:0] expv;
  } exp_t;

  exp_t exp_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  relay_hold_ctrl #(
    .DEBOUNCE_CYC(32'd4),
    .MIN_ON_CYC  (32'd8),
    .MIN_OFF_CYC (32'd6),
    .AUTO_OFF_CYC(32'd20),
    .CNT_W       (32'd16)
  ) dut (
    .Clk_i    (clk),
    .Reset_i  (Reset_i),
    .Switch_i (Switch_i),
    .Cmd_on_i (Cmd_on_i),
    .Cmd_off_i(Cmd_off_i),
    .Relay_o  (Relay_o),
    .Busy_o   (Busy_o),
    .State_o  (State_o),
    .Timeout_o(Timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks_cnt++;
    if (obs !== expv) begin
      errors_cnt++;
      $display("FAIL %s: got {relay,busy,state,timeout}=%b expected %b", tag, obs, expv);
    end
  endtask

  // Relay is energised in ON_HOLD/ON; busy in the two hold states
  function automatic logic [4:0] exp_vec(input logic [1:0] st, input logic to);
    logic relay, busy;
    relay = (st == 2'b01) || (st == 2'b10);
    busy  = (st == 2'b01) || (st == 2'b11);
    return {relay, busy, st, to};
  endfunction

  task automatic step(input logic rst, input logic on, input logic off, input logic sw,
                      input bit chk, input logic [1:0] st, input logic to, input string tag);
    exp_t e;
    @(negedge clk);
    Reset_i   = rst;
    Cmd_on_i  = on;
    Cmd_off_i = off;
    Switch_i  = sw;
    if (chk) begin
      e.tag  = tag;
      e.expv = exp_vec(st, to);
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input int n, input logic rst, input logic on, input logic off, input logic sw,
                     input logic [1:0] st, input logic to, input string tag);
    for (int i = 0; i < n; i++) begin
      step(rst, on, off, sw, 1'b1, st, to, tag);
    end
  endtask

  // Monitor: compare outputs shortly after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq(e.tag, {Relay_o, Busy_o, State_o, Timeout_o}, e.expv);
      end
    end
  end

  initial begin
    logic [13:0] bounce;
    bounce = 14'b10110111011000;

    // Reset, then release with Cmd_on in the first cycle
    run(2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "reset");
    run(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, "rel_hold");
    run(4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "rel_hold");
    run(8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, "on_hold");
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, "on_enter");

    // Auto-off after 20 ON cycles; a simultaneous Cmd_on loses to the timeout
    run(19, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, "on_auto");
    run(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, "timeout");
    run(5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "to_hold");
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "to_off");

    // On and off together: off wins
    run(1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "on_off_same");
    run(4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "on_off_same");

    // Bouncing switch with short runs: no change
    for (int i = 13; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b0, bounce[i], 1'b1, 2'b00, 1'b0, "bounce");
    end

    // Stable press: relay rises 8 edges later; Cmd_off at hold cycle 2
    run(7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "sw_lat");
    run(2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, "sw_rise");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, "cmd_off_hold");
    run(5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, "hold_full");
    run(6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "off_hold");
    run(2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "off_again");

    // Cmd_off coinciding with sw_press discards the press
    run(6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "sw_off_pre");
    run(1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, "off_sw_same");
    run(3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "off_sw_same");
    run(8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "sw_release");

    // Cmd_on coinciding with sw_press turns the relay on
    run(6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "sw_on_pre");
    run(1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, "on_sw_same");
    run(1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, "on_sw_rise");
    run(7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, "on_sw_hold");
    run(2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, "on_sw_on");

    // Reset while ON: relay drops at once, next Cmd_on waits out OFF_HOLD
    run(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "rst_on");
    run(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, "rst_hold");
    run(4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, "rst_hold");
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, "rst_on_hold");

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "drain");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "drain");
    check_eq("drain", 5'(exp_q.size()), 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/relay_hold_ctrl.md
Name: relay_hold_ctrl

Overview:
- Control FSM that sequences the HL-52S relay driver output.
- Merges two requesters onto one relay: a raw mechanical switch, which is synchronised, debounced and acts as a toggle, and host on/off command pulses.
- Enforces minimum energised and de-energised dwell times to protect relay contacts, with an optional auto-off timeout.
- Sits between board inputs/host logic and the relay pin, in place of driving the relay from the switch directly.

Parameters:
- DEBOUNCE_CYC, 500000, consecutive stable synchronised cycles before the debounced switch level changes (10 ms at 50 MHz); must be >= 1.
- MIN_ON_CYC, 5000000, minimum cycles the relay stays energised once turned on; must be >= 1.
- MIN_OFF_CYC, 5000000, minimum cycles the relay stays off once turned off, including after reset; must be >= 1.
- AUTO_OFF_CYC, 0, cycles in ON before forced switch-off; 0 disables auto-off.
- CNT_W, 32, width of the debounce, hold and auto-off counters; every CYC parameter must be < 2^CNT_W.

Ports:
- Clk_i, input, 1, system clock; the single clock domain.
- Reset_i, input, 1, synchronous, active-high reset.
- Switch_i, input, 1, raw asynchronous push-button; a debounced rising edge toggles the request.
- Cmd_on_i, input, 1, host request-on, single-cycle pulse, synchronous to Clk_i.
- Cmd_off_i, input, 1, host request-off, single-cycle pulse, synchronous to Clk_i.
- Relay_o, output, 1, registered relay drive.
- Busy_o, output, 1, high while in ON_HOLD or OFF_HOLD.
- State_o, output, 2, FSM state: 00 OFF, 01 ON_HOLD, 10 ON, 11 OFF_HOLD.
- Timeout_o, output, 1, one-cycle pulse when auto-off fires.

Behaviour:
- Reset values (Reset_i high at an edge):
  - sync FFs = 0, debounced level = 0, debounce counter = 0;
  - desired_r = 0, hold counter = 0, auto-off counter = 0;
  - state = OFF_HOLD, so Relay_o = 0, Busy_o = 1, State_o = 11, Timeout_o = 0.
  - The relay therefore cannot energise until MIN_OFF_CYC cycles after reset release.
  - Reset mid-operation from any state gives the same result: Relay_o = 0 after that edge.
- Switch path:
  - Switch_i passes through a 2-FF synchroniser.
  - The debounce counter increments while the synchronised value differs from the debounced level, and clears when they are equal.
  - When the count reaches DEBOUNCE_CYC-1 while still differing, the debounced level takes the synchronised value and the counter clears.
  - A 0->1 change of the debounced level produces sw_press, a 1-cycle internal pulse. Release produces nothing.
- desired_r update, by priority per edge:
  1. Cmd_off_i → 0. This also covers Cmd_on_i and Cmd_off_i together: off wins.
  2. Cmd_on_i → 1.
  3. sw_press → ~desired_r.
  - A host command in the same cycle as sw_press overrides the switch. The switch press is discarded.
- FSM; Relay_o is registered and equals 1 exactly in ON_HOLD and ON:
  - OFF: if desired_r = 1, go to ON_HOLD and clear the hold counter.
  - ON_HOLD: the hold counter increments. At count MIN_ON_CYC-1, go to ON if desired_r = 1, else go to OFF_HOLD. Requests made during the hold are only latched in desired_r.
  - ON: the auto-off counter increments.
    - If desired_r = 0, go to OFF_HOLD.
    - Else if AUTO_OFF_CYC ≠ 0 and the count reaches AUTO_OFF_CYC-1: go to OFF_HOLD, clear desired_r, and pulse Timeout_o for 1 cycle.
    - If a host Cmd_on_i lands in the same cycle as auto-off, the timeout wins.
  - OFF_HOLD: the hold counter increments. At count MIN_OFF_CYC-1, go to ON_HOLD if desired_r = 1, else go to OFF.
  - Hold and auto-off counters clear on every state entry.
- Residency and latency:
  - Each hold state lasts exactly MIN_x_CYC cycles.
  - Host command to Relay_o change, from state OFF or ON: 2 edges. The command is sampled at edge k, and Relay_o changes after edge k+1.
  - Switch to Relay_o: 2 sync edges + DEBOUNCE_CYC + 2 edges.
- Counters saturate; no wrap-around is possible given the CNT_W constraint.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, MIN_ON_CYC=8, MIN_OFF_CYC=6, AUTO_OFF_CYC=20.
- Reset release, with Cmd_on_i pulsed in the first cycle → Relay_o stays 0 and Busy_o = 1 for 6 cycles, then Relay_o = 1 and State_o = 01 for 8 cycles, then State_o = 10.
- Switch_i bouncing with runs of 1–3 cycles → no Relay_o change. Switch_i then held high for 10 cycles → exactly one toggle; Relay_o rises 2+4+2 edges after the stable level.
- In ON_HOLD, Cmd_off_i at hold cycle 2 → Relay_o stays 1 through the full 8 cycles, then State_o = 11 with Relay_o = 0 for 6 cycles, then State_o = 00.
- Relay in ON, no commands → after 20 cycles, Timeout_o is high for exactly 1 cycle, Relay_o = 0, and desired_r = 0 (the relay stays off after OFF_HOLD).
- In OFF, Cmd_on_i and Cmd_off_i in the same cycle → Relay_o stays 0. Cmd_on_i in the same cycle as sw_press → desired_r = 1 and the relay turns on.
- In ON, Reset_i asserted for 1 cycle → Relay_o = 0 on the next edge, State_o = 11, and a subsequent Cmd_on_i is honoured only after 6 cycles.
